memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/mem_pkg.sv | 10 +
 rtl/memory_if.sv | 15 +
 rtl/memory.sv | 45 ++++
 tb/tb_memory.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and word/address types for the single-port memory.
package mem_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/memory_if.sv
// Access bus of the single-port memory: one access per clock, no handshake.
interface memory_if #(
  parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
);

  logic                  wen;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output wen, output address, output data_in, input  data_out);
  modport slave  (input  wen, input  address, input  data_in, output data_out);

endinterface

// File: rtl/memory.sv
// Single-port, write-first memory with a registered output and an
// asynchronous clear of both the storage array and the output register.
module memory #(
  parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  always_comb begin
    mem_d      = mem_q;
    data_out_d = mem_q[address];
    if (wen) begin
      mem_d[address] = data_in;
      data_out_d     = data_in;
    end
  end

  // NOTE: the array must read as zero the instant rst rises, so it is built
  // from resettable flops rather than a RAM macro, which cannot be cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed vector table, async reset
// sequence, then random traffic against an array-based reference model.
module tb_memory;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  memory_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  memory #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (bus.wen),
    .address  (bus.address),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  wen;
    addr_t addr;
    word_t din;
    word_t exp;
    string name;
  } vec_t;

  vec_t  vecs [$];
  int    ref_mem [2**ADDR_WIDTH];

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: data_out=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, sample, and
  // return at the next falling edge.
  task automatic apply(input logic w, input addr_t a, input word_t d,
                       output word_t got);
    bus.wen     = w;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    #1 got = bus.data_out;
    @(negedge clk);
  endtask

  initial begin
    word_t got;
    word_t exp;
    addr_t a;
    word_t d;
    logic  w;

    bus.wen     = 1'b0;
    bus.address = '0;
    bus.data_in = '0;

    #1 rst = 1'b1;
    #1 check("reset_dout", bus.data_out, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{1'b0, 8'd0,   8'd0,   8'd0,   "rd0_after_rst"});
    vecs.push_back('{1'b0, 8'd184, 8'd0,   8'd0,   "rd184_after_rst"});
    vecs.push_back('{1'b0, 8'd255, 8'd0,   8'd0,   "rd255_after_rst"});
    vecs.push_back('{1'b1, 8'd184, 8'd12,  8'd12,  "wr184_through"});
    vecs.push_back('{1'b1, 8'd0,   8'd34,  8'd34,  "wr0_through"});
    vecs.push_back('{1'b0, 8'd184, 8'd58,  8'd12,  "rd184_ignore_din"});
    vecs.push_back('{1'b0, 8'd0,   8'd73,  8'd34,  "rd0_ignore_din"});
    vecs.push_back('{1'b1, 8'd255, 8'd200, 8'd200, "wr255_through"});
    vecs.push_back('{1'b0, 8'd255, 8'd1,   8'd200, "rd255"});
    vecs.push_back('{1'b0, 8'd0,   8'd2,   8'd34,  "rd0_no_alias"});
    vecs.push_back('{1'b1, 8'd10,  8'd7,   8'd7,   "wr10_through"});
    vecs.push_back('{1'b0, 8'd10,  8'd0,   8'd7,   "rd10_back_to_back"});
    vecs.push_back('{1'b0, 8'd184, 8'd0,   8'd12,  "rd184_still"});

    foreach (vecs[i]) begin
      apply(vecs[i].wen, vecs[i].addr, vecs[i].din, got);
      check(vecs[i].name, got, vecs[i].exp);
    end

    // Reset asserted between edges while a write of 99 to address 5 is pending.
    bus.wen     = 1'b1;
    bus.address = 8'd5;
    bus.data_in = 8'd99;
    #2 rst = 1'b1;
    #1 check("rst_async_dout", bus.data_out, 8'd0);
    @(posedge clk);
    #1 check("rst_hold_dout", bus.data_out, 8'd0);
    @(negedge clk);
    rst     = 1'b0;
    bus.wen = 1'b0;

    apply(1'b0, 8'd5,   8'd0, got); check("rd5_write_discarded", got, 8'd0);
    apply(1'b0, 8'd184, 8'd0, got); check("rd184_cleared", got, 8'd0);
    apply(1'b0, 8'd255, 8'd0, got); check("rd255_cleared", got, 8'd0);
    apply(1'b0, 8'd10,  8'd0, got); check("rd10_cleared", got, 8'd0);

    // Random traffic, edge addresses weighted heavily.
    foreach (ref_mem[i]) ref_mem[i] = 0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(3))
        0:       a = '0;
        1:       a = '1;
        default: a = addr_t'($urandom);
      endcase
      w = 1'($urandom);
      d = word_t'($urandom);
      if (w) begin
        ref_mem[a] = int'(d);
        exp = d;
      end else begin
        exp = word_t'(ref_mem[a]);
      end
      apply(w, a, d, got);
      check($sformatf("rand%0d_%s_a%0d", n, w ? "wr" : "rd", a), got, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
